// File: rtl/dut_vector_sequencer.sv
// Batch stimulus/result sequencer for the 20-in/10-out bit datapath.
// Steps stored vectors onto dp_in and captures dp_out[5:0] per vector.
//
// Ports:
//   clk, rst          rising-edge clock, sync active-high reset
//   load_valid/addr/  stimulus memory write (accepted in IDLE only)
//   load_data
//   start, count      launch a run of count (1..DEPTH) vectors
//   busy, done, err   status; done/err are one-cycle pulses
//   dp_in, dp_out     registered vector out, combinational response in
//   rd_addr, rd_data  registered result readback (always active)
module dut_vector_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [AW-1:0] load_addr,
  input  logic [19:0]   load_data,
  input  logic          start,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [19:0]   dp_in,
  input  logic [9:0]    dp_out,
  input  logic [AW-1:0] rd_addr,
  output logic [9:0]    rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic [19:0]   r_stim [DEPTH];
  logic [9:0]    r_res  [DEPTH];
  logic [AW-1:0] r_idx;
  logic [AW:0]   r_cnt;
  logic [19:0]   r_dp_in;
  logic [9:0]    r_rd_data;
  logic          r_err;

  logic w_idle;
  logic w_cap;
  logic w_cnt_ok;
  logic w_last;
  logic w_go;
  logic w_unused_dp;

  assign w_idle   = (r_state == S_IDLE);
  assign w_cap    = (r_state == S_CAPTURE);
  assign w_cnt_ok = (count != '0) && (count <= LP_DEPTH);
  assign w_go     = w_idle && start && w_cnt_ok;
  // idx+1 is compared at AW+1 bits so count=DEPTH ends without wrap
  assign w_last   = (({1'b0, r_idx} + (AW+1)'(1)) == r_cnt);

  // upper response bits are undriven by the datapath
  assign w_unused_dp = ^dp_out[9:6];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_go) w_next = S_APPLY;
      S_APPLY:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = w_last ? S_DONE : S_APPLY;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_dp_in   <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err     <= w_idle && start && !w_cnt_ok;
      r_rd_data <= r_res[rd_addr];
      if (w_go) begin
        r_cnt <= count;
        r_idx <= '0;
      end
      if (r_state == S_APPLY) r_dp_in <= r_stim[r_idx];
      if (w_cap && !w_last)   r_idx   <= r_idx + AW'(1);
    end
  end

  // memories are not reset; contents persist across runs
  always_ff @(posedge clk) begin
    if (!rst && w_idle && load_valid)
      r_stim[load_addr] <= load_data;
    if (!rst && w_cap)
      r_res[r_idx] <= {4'b0000, dp_out[5:0]};
  end

  assign busy    = !w_idle;
  assign done    = (r_state == S_DONE);
  assign err     = r_err;
  assign dp_in   = r_dp_in;
  assign rd_data = r_rd_data;

endmodule
